// File: rtl/bsg_transpose_stream_if.sv
// ============================================================================
// Module      : bsg_transpose_stream_if
// Description : Row-in (valid/ready) and column-out (valid/yumi) stream bundle
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface bsg_transpose_stream_if #(
  parameter int width_p = 16,
  parameter int els_p   = 16
);
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               v_o;
  logic [els_p-1:0]   data_o;
  logic               yumi_i;

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o
  );

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o
  );
endinterface

`default_nettype wire

// File: rtl/bsg_transpose_stream.sv
// ============================================================================
// Module      : bsg_transpose_stream
// Description : Buffers els_p rows of width_p bits, then emits width_p columns
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bsg_transpose_stream #(
  parameter int width_p = 16,
  parameter int els_p   = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bsg_transpose_stream_if.slave io
);

  localparam int c_row_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int c_col_w = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(els_p - 1);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(width_p - 1);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_row_w-1:0]   r_row_cnt;
  logic [c_row_w-1:0]   w_row_cnt_nxt;
  logic [c_col_w-1:0]   r_col_cnt;
  logic [c_col_w-1:0]   w_col_cnt_nxt;
  logic [width_p-1:0]   r_buf [els_p];
  logic                 w_ready;
  logic                 w_valid;
  logic                 w_row_fire;
  logic                 w_col_fire;
  logic [els_p-1:0]     w_col_word;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= ST_FILL;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_col_cnt <= w_col_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_col_cnt_nxt = r_col_cnt;
    w_ready       = 1'b0;
    w_valid       = 1'b0;
    w_row_fire    = 1'b0;
    w_col_fire    = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_ready    = ~reset_i;
        w_row_fire = w_ready & io.v_i;
        if (w_row_fire) begin
          if (r_row_cnt == c_row_last) begin
            w_row_cnt_nxt = '0;
            w_state_nxt   = ST_DRAIN;
          end else begin
            w_row_cnt_nxt = r_row_cnt + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        w_valid    = ~reset_i;
        // yumi is only honoured while a column is actually offered
        w_col_fire = w_valid & io.yumi_i;
        if (w_col_fire) begin
          if (r_col_cnt == c_col_last) begin
            w_col_cnt_nxt = '0;
            w_state_nxt   = ST_FILL;
          end else begin
            w_col_cnt_nxt = r_col_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_row_fire) begin
      r_buf[r_row_cnt] <= io.data_i;
    end
  end

  always_comb begin
    w_col_word = '0;
    for (int r = 0; r < els_p; r++) begin
      w_col_word[r] = r_buf[r][r_col_cnt];
    end
  end

  assign io.ready_o = w_ready;
  assign io.v_o     = w_valid;
  assign io.data_o  = w_col_word;

endmodule

`default_nettype wire
